// File: rtl/data_cache_assoc_if.sv
// CPU-side request/response and main-memory line-transfer signals of the data cache.
// The slave modport is the cache's own view; master is the CPU/memory environment.
interface data_cache_assoc_if;
  logic         read;
  logic         write;
  logic [3:0]   byte_en;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         MAIN_MEM_READ;
  logic         MAIN_MEM_WRITE;
  logic [27:0]  MAIN_MEM_ADDRESS;
  logic [127:0] MAIN_MEM_WRITE_DATA;
  logic [127:0] MAIN_MEM_READ_DATA;
  logic         MAIN_MEM_BUSY_WAIT;

  modport slave (
    input  read, write, byte_en, address, writedata,
    input  MAIN_MEM_READ_DATA, MAIN_MEM_BUSY_WAIT,
    output readdata, busywait,
    output MAIN_MEM_READ, MAIN_MEM_WRITE, MAIN_MEM_ADDRESS, MAIN_MEM_WRITE_DATA
  );

  modport master (
    output read, write, byte_en, address, writedata,
    output MAIN_MEM_READ_DATA, MAIN_MEM_BUSY_WAIT,
    input  readdata, busywait,
    input  MAIN_MEM_READ, MAIN_MEM_WRITE, MAIN_MEM_ADDRESS, MAIN_MEM_WRITE_DATA
  );
endinterface

// File: rtl/data_cache_assoc.sv
// Write-back, write-allocate data cache, 1- or 2-way set associative, 16-byte lines.
// Hits complete combinationally with zero stall; misses stall via busywait through WRITEBACK/FETCH.
module data_cache_assoc #(
  parameter int INDEX_BITS = 3,
  parameter int WAYS       = 2
) (
  input  logic              clock,
  input  logic              reset,
  data_cache_assoc_if.slave bus
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t state_q, state_d;

  // Storage is always two ways wide; way 1 never becomes valid when WAYS == 1.
  logic                valid_q [0:1][0:SETS-1];
  logic                dirty_q [0:1][0:SETS-1];
  logic [TAG_BITS-1:0] tag_q   [0:1][0:SETS-1];
  logic [127:0]        line_q  [0:1][0:SETS-1];
  logic                lru_q   [0:SETS-1];

  // Miss context is captured so an abandoned request still finishes its transfer.
  logic                  miss_way_q, miss_way_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;

  logic                  req;
  logic [1:0]            word;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            hit_vec;
  logic                  hit;
  logic                  hit_way;
  logic                  victim;
  logic                  hit_upd;
  logic                  wr_hit;
  logic                  wb_done;
  logic                  fill;
  logic                  addr_unused;

  assign req         = bus.read ^ bus.write;
  assign word        = bus.address[3:2];
  assign idx         = bus.address[3+INDEX_BITS:4];
  assign tag         = bus.address[31:4+INDEX_BITS];
  assign addr_unused = ^bus.address[1:0];

  always_comb begin
    hit_vec = 2'b00;
    for (int w = 0; w < 2; w++) begin
      hit_vec[w] = (w < WAYS) && valid_q[w][idx] && (tag_q[w][idx] == tag);
    end
  end

  assign hit     = |hit_vec;
  assign hit_way = hit_vec[1];

  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!valid_q[0][idx])      victim = 1'b0;
      else if (!valid_q[1][idx]) victim = 1'b1;
      else                       victim = lru_q[idx];
    end
  end

  assign bus.readdata            = line_q[hit_way][idx][{word, 5'b00000} +: 32];
  assign bus.busywait            = req && !(state_q == IDLE && hit) && !reset;
  assign bus.MAIN_MEM_WRITE_DATA = line_q[miss_way_q][miss_idx_q];

  assign hit_upd = (state_q == IDLE) && req && hit;
  assign wr_hit  = hit_upd && bus.write && (bus.byte_en != 4'b0000);
  assign wb_done = (state_q == WRITEBACK) && !bus.MAIN_MEM_BUSY_WAIT;
  assign fill    = (state_q == FETCH) && !bus.MAIN_MEM_BUSY_WAIT;

  always_comb begin
    state_d              = state_q;
    miss_way_d           = miss_way_q;
    miss_idx_d           = miss_idx_q;
    miss_tag_d           = miss_tag_q;
    bus.MAIN_MEM_READ    = 1'b0;
    bus.MAIN_MEM_WRITE   = 1'b0;
    bus.MAIN_MEM_ADDRESS = {miss_tag_q, miss_idx_q};
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          miss_way_d = victim;
          miss_idx_d = idx;
          miss_tag_d = tag;
          state_d    = (valid_q[victim][idx] && dirty_q[victim][idx]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        bus.MAIN_MEM_WRITE   = 1'b1;
        bus.MAIN_MEM_ADDRESS = {tag_q[miss_way_q][miss_idx_q], miss_idx_q};
        if (!bus.MAIN_MEM_BUSY_WAIT) state_d = FETCH;
      end
      FETCH: begin
        bus.MAIN_MEM_READ = 1'b1;
        if (!bus.MAIN_MEM_BUSY_WAIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      miss_way_q <= 1'b0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      state_q    <= state_d;
      miss_way_q <= miss_way_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      if (wb_done) dirty_q[miss_way_q][miss_idx_q] <= 1'b0;
      if (fill) begin
        valid_q[miss_way_q][miss_idx_q] <= 1'b1;
        dirty_q[miss_way_q][miss_idx_q] <= 1'b0;
      end
      if (hit_upd) lru_q[idx] <= ~hit_way;
      if (wr_hit)  dirty_q[hit_way][idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies their contents.
  always_ff @(posedge clock) begin
    if (fill) begin
      line_q[miss_way_q][miss_idx_q] <= bus.MAIN_MEM_READ_DATA;
      tag_q[miss_way_q][miss_idx_q]  <= miss_tag_q;
    end else if (wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byte_en[b]) line_q[hit_way][idx][{word, 2'(b), 3'b000} +: 8] <= bus.writedata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_cache_assoc.sv
// Directed bench: a 2-way/8-set cache and a direct-mapped/4-set cache, each with a latency-3 memory.
module tb_data_cache_assoc;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  data_cache_assoc_if bus0();
  data_cache_assoc_if bus1();

  data_cache_assoc #(.INDEX_BITS(3), .WAYS(2)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  data_cache_assoc #(.INDEX_BITS(2), .WAYS(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [127:0] mem0 [logic [27:0]];
  logic [127:0] mem1 [logic [27:0]];
  logic [28:0]  log0 [$];
  logic [28:0]  log1 [$];
  int           cnt0 = 0, cnt1 = 0, both0 = 0, both1 = 0;

  // Unwritten memory line at address a holds word w = {w, a}.
  function automatic logic [127:0] line_of(input logic [27:0] a);
    return {4'h3, a, 4'h2, a, 4'h1, a, 4'h0, a};
  endfunction

  initial begin
    bus0.MAIN_MEM_BUSY_WAIT = 1'b1;
    bus0.MAIN_MEM_READ_DATA = '0;
    forever begin
      @(negedge clock);
      if (bus0.MAIN_MEM_READ && bus0.MAIN_MEM_WRITE) both0++;
      if (bus0.MAIN_MEM_READ || bus0.MAIN_MEM_WRITE) begin
        cnt0++;
        bus0.MAIN_MEM_READ_DATA = mem0.exists(bus0.MAIN_MEM_ADDRESS) ?
                                  mem0[bus0.MAIN_MEM_ADDRESS] : line_of(bus0.MAIN_MEM_ADDRESS);
        if (cnt0 > 3) begin
          bus0.MAIN_MEM_BUSY_WAIT = 1'b0;
          cnt0 = 0;
          log0.push_back({bus0.MAIN_MEM_WRITE, bus0.MAIN_MEM_ADDRESS});
          if (bus0.MAIN_MEM_WRITE) mem0[bus0.MAIN_MEM_ADDRESS] = bus0.MAIN_MEM_WRITE_DATA;
        end else bus0.MAIN_MEM_BUSY_WAIT = 1'b1;
      end else begin
        cnt0 = 0;
        bus0.MAIN_MEM_BUSY_WAIT = 1'b1;
      end
    end
  end

  initial begin
    bus1.MAIN_MEM_BUSY_WAIT = 1'b1;
    bus1.MAIN_MEM_READ_DATA = '0;
    forever begin
      @(negedge clock);
      if (bus1.MAIN_MEM_READ && bus1.MAIN_MEM_WRITE) both1++;
      if (bus1.MAIN_MEM_READ || bus1.MAIN_MEM_WRITE) begin
        cnt1++;
        bus1.MAIN_MEM_READ_DATA = mem1.exists(bus1.MAIN_MEM_ADDRESS) ?
                                  mem1[bus1.MAIN_MEM_ADDRESS] : line_of(bus1.MAIN_MEM_ADDRESS);
        if (cnt1 > 3) begin
          bus1.MAIN_MEM_BUSY_WAIT = 1'b0;
          cnt1 = 0;
          log1.push_back({bus1.MAIN_MEM_WRITE, bus1.MAIN_MEM_ADDRESS});
          if (bus1.MAIN_MEM_WRITE) mem1[bus1.MAIN_MEM_ADDRESS] = bus1.MAIN_MEM_WRITE_DATA;
        end else bus1.MAIN_MEM_BUSY_WAIT = 1'b1;
      end else begin
        cnt1 = 0;
        bus1.MAIN_MEM_BUSY_WAIT = 1'b1;
      end
    end
  end

  task automatic acc0(input logic r, input logic w, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd, output int stalls, output logic [31:0] rd);
    @(negedge clock);
    bus0.read = r; bus0.write = w; bus0.byte_en = be; bus0.address = a; bus0.writedata = wd;
    stalls = 0;
    #1;
    while (bus0.busywait === 1'b1 && stalls < 100) begin
      @(negedge clock); #1; stalls++;
    end
    rd = bus0.readdata;
    @(negedge clock);
    bus0.read = 1'b0; bus0.write = 1'b0;
  endtask

  task automatic acc1(input logic r, input logic w, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd, output int stalls, output logic [31:0] rd);
    @(negedge clock);
    bus1.read = r; bus1.write = w; bus1.byte_en = be; bus1.address = a; bus1.writedata = wd;
    stalls = 0;
    #1;
    while (bus1.busywait === 1'b1 && stalls < 100) begin
      @(negedge clock); #1; stalls++;
    end
    rd = bus1.readdata;
    @(negedge clock);
    bus1.read = 1'b0; bus1.write = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock); #1;
    checks++; if (bus0.busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %b expected 0", bus0.busywait); end
    checks++; if (bus0.MAIN_MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", bus0.MAIN_MEM_READ); end
    checks++; if (bus0.MAIN_MEM_WRITE !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", bus0.MAIN_MEM_WRITE); end
    checks++; if (bus1.busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait_dm: got %b expected 0", bus1.busywait); end
    @(negedge clock);
    reset = 1'b0; bus0.read = 1'b0; bus1.read = 1'b0;
  endtask

  task automatic test_read_miss();
    int st; logic [31:0] rd;
    log0.delete();
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL miss_stalls: got %0d expected 5", st); end
    checks++; if (rd !== 32'hBBBBAAAA) begin errors++; $display("FAIL miss_rdata: got %h expected bbbbaaaa", rd); end
    checks++; if (log0.size() != 1 || log0[0] !== {1'b0, 28'h4}) begin
      errors++; $display("FAIL miss_fetch_addr: got %0d transfers expected one fetch of 0000004", log0.size()); end
  endtask

  task automatic test_write_hit();
    int st; logic [31:0] rd;
    acc0(1'b0, 1'b1, 4'b0110, 32'h0000_0044, 32'h12345678, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL whit_stalls: got %0d expected 0", st); end
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL whit_rd_stalls: got %0d expected 0", st); end
    checks++; if (rd !== 32'hDD3456CC) begin errors++; $display("FAIL whit_rdata: got %h expected dd3456cc", rd); end
    acc0(1'b0, 1'b1, 4'b0000, 32'h0000_0048, 32'hFFFFFFFF, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL be0_stalls: got %0d expected 0", st); end
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0048, 32'h0, st, rd);
    checks++; if (rd !== 32'h22221111) begin errors++; $display("FAIL be0_rdata: got %h expected 22221111", rd); end
  endtask

  task automatic test_lru_evict();
    int st; logic [31:0] rd; logic [127:0] wb;
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_00C0, 32'h0, st, rd);
    checks++; if (st !== 5 || rd !== 32'h0000000C) begin errors++; $display("FAIL fill_b: got %0d/%h expected 5/0000000c", st, rd); end
    acc0(1'b0, 1'b1, 4'hF, 32'h0000_00C4, 32'hCAFEF00D, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL dirty_b_stalls: got %0d expected 0", st); end
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0, st, rd);
    checks++; if (st !== 0 || rd !== 32'hBBBBAAAA) begin errors++; $display("FAIL touch_a: got %0d/%h expected 0/bbbbaaaa", st, rd); end
    log0.delete();
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0140, 32'h0, st, rd);
    checks++; if (st !== 9) begin errors++; $display("FAIL evict_stalls: got %0d expected 9", st); end
    checks++; if (rd !== 32'h00000014) begin errors++; $display("FAIL evict_rdata: got %h expected 00000014", rd); end
    checks++; if (log0.size() != 2 || log0[0] !== {1'b1, 28'hC} || log0[1] !== {1'b0, 28'h14}) begin
      errors++; $display("FAIL evict_order: got %0d transfers expected write 000000c then read 0000014", log0.size()); end
    wb = mem0.exists(28'hC) ? mem0[28'hC] : 128'h0;
    checks++; if (wb !== {32'h3000000C, 32'h2000000C, 32'hCAFEF00D, 32'h0000000C}) begin
      errors++; $display("FAIL evict_data: got %h expected 3000000c2000000ccafef00d0000000c", wb); end
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0, st, rd);
    checks++; if (st !== 0 || rd !== 32'hDD3456CC) begin errors++; $display("FAIL a_kept: got %0d/%h expected 0/dd3456cc", st, rd); end
  endtask

  task automatic test_write_miss();
    int st; logic [31:0] rd;
    acc0(1'b0, 1'b1, 4'b0001, 32'h0000_0200, 32'h000000AB, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL wmiss_stalls: got %0d expected 5", st); end
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0, st, rd);
    checks++; if (st !== 0 || rd !== 32'h000000AB) begin errors++; $display("FAIL wmiss_rdata: got %0d/%h expected 0/000000ab", st, rd); end
  endtask

  task automatic test_both();
    int seen = 0;
    log0.delete();
    @(negedge clock);
    bus0.read = 1'b1; bus0.write = 1'b1; bus0.byte_en = 4'hF; bus0.address = 32'h0000_0300; bus0.writedata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus0.busywait !== 1'b0 || bus0.MAIN_MEM_READ !== 1'b0 || bus0.MAIN_MEM_WRITE !== 1'b0) seen++;
      @(negedge clock);
    end
    bus0.read = 1'b0; bus0.write = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL rw_both: got %0d busy/strobe cycles expected 0", seen); end
    checks++; if (log0.size() != 0) begin errors++; $display("FAIL rw_both_xfer: got %0d transfers expected 0", log0.size()); end
  endtask

  task automatic test_drop();
    int st; logic [31:0] rd;
    log0.delete();
    @(negedge clock);
    bus0.read = 1'b0; bus0.write = 1'b1; bus0.byte_en = 4'hF; bus0.address = 32'h0000_0600; bus0.writedata = 32'hFFFFFFFF;
    repeat (2) @(negedge clock);
    bus0.write = 1'b0;
    repeat (8) @(negedge clock);
    #1;
    checks++; if (bus0.MAIN_MEM_READ !== 1'b0 || log0.size() != 1 || log0[0] !== {1'b0, 28'h60}) begin
      errors++; $display("FAIL drop_xfer: got read=%b transfers=%0d expected 0/one fetch of 0000060", bus0.MAIN_MEM_READ, log0.size()); end
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0600, 32'h0, st, rd);
    checks++; if (st !== 0 || rd !== 32'h00000060) begin errors++; $display("FAIL drop_no_write: got %0d/%h expected 0/00000060", st, rd); end
  endtask

  task automatic test_reset_fetch();
    int st; logic [31:0] rd;
    @(negedge clock);
    bus0.read = 1'b1; bus0.write = 1'b0; bus0.address = 32'h0000_0530;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (bus0.MAIN_MEM_READ !== 1'b1) begin errors++; $display("FAIL rst_pre_fetch: got %b expected 1", bus0.MAIN_MEM_READ); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus0.MAIN_MEM_READ !== 1'b0 || bus0.MAIN_MEM_WRITE !== 1'b0 || bus0.busywait !== 1'b0) begin
      errors++; $display("FAIL rst_abort: got rd=%b wr=%b busy=%b expected 0/0/0", bus0.MAIN_MEM_READ, bus0.MAIN_MEM_WRITE, bus0.busywait); end
    @(negedge clock);
    bus0.read = 1'b0; reset = 1'b0;
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0530, 32'h0, st, rd);
    checks++; if (st !== 5 || rd !== 32'h00000053) begin errors++; $display("FAIL rst_reread: got %0d/%h expected 5/00000053", st, rd); end
    acc0(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0, st, rd);
    checks++; if (st !== 5 || rd !== 32'hBBBBAAAA) begin errors++; $display("FAIL rst_invalid: got %0d/%h expected 5/bbbbaaaa", st, rd); end
  endtask

  task automatic test_direct();
    int st; logic [31:0] rd; logic [127:0] wb;
    log1.delete();
    acc1(1'b0, 1'b1, 4'hF, 32'h0000_0000, 32'h11223344, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL dm_wmiss: got %0d expected 5", st); end
    acc1(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0, st, rd);
    checks++; if (st !== 9 || rd !== 32'h00000004) begin errors++; $display("FAIL dm_conflict: got %0d/%h expected 9/00000004", st, rd); end
    checks++; if (log1.size() != 3 || log1[1] !== {1'b1, 28'h0} || log1[2] !== {1'b0, 28'h4}) begin
      errors++; $display("FAIL dm_order: got %0d transfers expected fetch 0, write 0000000, read 0000004", log1.size()); end
    wb = mem1.exists(28'h0) ? mem1[28'h0] : 128'h0;
    checks++; if (wb !== {32'h30000000, 32'h20000000, 32'h10000000, 32'h11223344}) begin
      errors++; $display("FAIL dm_wb_data: got %h expected 30000000200000001000000011223344", wb); end
    acc1(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0, st, rd);
    checks++; if (st !== 5 || rd !== 32'h11223344) begin errors++; $display("FAIL dm_refetch: got %0d/%h expected 5/11223344", st, rd); end
  endtask

  task automatic test_no_overlap();
    checks++; if (both0 != 0 || both1 != 0) begin
      errors++; $display("FAIL strobe_overlap: got %0d/%0d cycles expected 0/0", both0, both1); end
  endtask

  initial begin
    reset = 1'b1;
    bus0.read = 1'b1; bus0.write = 1'b0; bus0.byte_en = 4'h0; bus0.address = 32'h0000_0040; bus0.writedata = 32'h0;
    bus1.read = 1'b1; bus1.write = 1'b0; bus1.byte_en = 4'h0; bus1.address = 32'h0000_0040; bus1.writedata = 32'h0;
    mem0[28'h4] = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
    test_reset();
    test_read_miss();
    test_write_hit();
    test_lru_evict();
    test_write_miss();
    test_both();
    test_drop();
    test_reset_fetch();
    test_direct();
    test_no_overlap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_cache_assoc.md
DATA_CACHE_ASSOC -- requirements
Module: data_cache_assoc

Interface
REQ-001 Parameter INDEX_BITS, default 3, meaning log2(number of sets); legal range 1..6.
REQ-002 Parameter WAYS, default 2, meaning associativity; legal values 1 (direct-mapped) and 2.
REQ-003 Port clock, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port read, input, 1 bit: CPU load request.
REQ-006 Port write, input, 1 bit: CPU store request.
REQ-007 Port byte_en, input, 4 bits: store byte lanes; bit n enables writedata[8n+7:8n].
REQ-008 Port address, input, 32 bits: CPU byte address.
REQ-009 Port writedata, input, 32 bits: store data, lane-aligned.
REQ-010 Port readdata, output, 32 bits: load data, full word.
REQ-011 Port busywait, output, 1 bit: request not yet complete; CPU stalls.
REQ-012 Port MAIN_MEM_READ, output, 1 bit: line fetch strobe.
REQ-013 Port MAIN_MEM_WRITE, output, 1 bit: line write-back strobe.
REQ-014 Port MAIN_MEM_ADDRESS, output, 28 bits: line address (byte address [31:4]).
REQ-015 Port MAIN_MEM_WRITE_DATA, output, 128 bits: victim line data.
REQ-016 Port MAIN_MEM_READ_DATA, input, 128 bits: fetched line data.
REQ-017 Port MAIN_MEM_BUSY_WAIT, input, 1 bit: memory busy; low means the current transfer completes at this edge.

Function
REQ-018 Line = 16 bytes (4 words); word = address[3:2]; index = address[3+INDEX_BITS:4]; tag = address[31:4+INDEX_BITS]; address[1:0] ignored.
REQ-019 Per set and way: valid bit, dirty bit, tag, 128-bit data; per set with WAYS=2: one LRU bit naming the least-recently-used way.
REQ-020 Hit = any way of the indexed set valid with matching tag; at most one way hits.
REQ-021 States: IDLE, WRITEBACK, FETCH; encoding free.
REQ-022 read and write both high: treated as no request; busywait 0; no state change.
REQ-023 busywait = (read or write, not both) AND NOT (state IDLE AND hit); combinational.
REQ-024 Read hit: readdata = selected word of hitting way, combinational, zero wait cycles; LRU updated at next edge.
REQ-025 Write hit: at next edge, enabled bytes written, line dirty set, LRU updated; byte_en = 0 writes nothing and does not set dirty.
REQ-026 Victim on miss: first invalid way (way 0 priority), else LRU way; WAYS=1 uses way 0.
REQ-027 Miss in IDLE: next edge goes to WRITEBACK if victim valid and dirty, else to FETCH.
REQ-028 WRITEBACK: MAIN_MEM_WRITE=1, address = {victim tag, index}, data = victim line; held constant; at an edge with MAIN_MEM_BUSY_WAIT=0, clear victim dirty and go to FETCH.
REQ-029 FETCH: MAIN_MEM_READ=1, address = {tag, index}; at an edge with MAIN_MEM_BUSY_WAIT=0, write MAIN_MEM_READ_DATA into victim, set valid, clear dirty, store tag, go to IDLE.
REQ-030 After FETCH, the request hits in IDLE and completes per REQ-024/REQ-025, one cycle after the fill edge.
REQ-031 MAIN_MEM_READ and MAIN_MEM_WRITE are never both 1; both are 0 in IDLE.
REQ-032 The requester holds address, read, write, byte_en and writedata stable while busywait=1; behaviour is undefined otherwise.
REQ-033 Request dropped mid-miss: the current transfer still completes and the FSM returns to IDLE; no CPU write occurs.
REQ-034 readdata is don't-care when not a read hit; it is driven with no X from the data array after a fill.

Reset
REQ-035 reset=1 immediately clears all valid, dirty and LRU bits, forces IDLE, MAIN_MEM_READ=0, MAIN_MEM_WRITE=0, and busywait=0 while it is asserted; data and tag arrays are not reset.
REQ-036 Reset mid-WRITEBACK or mid-FETCH aborts the transfer and drops strobes the same cycle; no partial line is written.

Verification
REQ-037 After reset, read 0x0000_0040, memory returns line 0x44443333_22221111_DDDDCCCC_BBBBAAAA after 3 busy cycles -> MAIN_MEM_READ with address 0x0000004, then readdata 0xBBBBAAAA, busywait low one cycle after the fill.
REQ-038 Write hit at 0x0000_0044, byte_en=0110, writedata 0x12345678 -> zero stall; read back 0xDD3456CC; line dirty.
REQ-039 WAYS=2: fill tags A and B into set 4, touch A, miss tag C -> B evicted; if B was dirty, MAIN_MEM_WRITE precedes MAIN_MEM_READ with B's address and data.
REQ-040 WAYS=1, INDEX_BITS=2: dirty line at 0x00, read 0x40 -> write-back of address 0x0000000, then fetch of 0x0000004; strobes are never simultaneous.
REQ-041 read=write=1 -> busywait 0 and no memory strobe; reset asserted during FETCH -> strobes low immediately; a re-read afterwards misses.
